// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: computes a + b + cin over WIDTH cycles with one
// full-adder cell and a registered carry, under a start/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Handshake: start is sampled only in IDLE (ignored, not queued, while busy);
  // operands are captured on the accepting edge; done pulses for one cycle with
  // sum/cout valid, and sum/cout then hold until the next done.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_next;

  // The single full-adder cell working on the current LSBs.
  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    res_next = {s_bit, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res   <= res_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          // Publish only the completed word so sum never shows partial bits.
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= c_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: scenario tasks with a scoreboard queue of expected
// {cout,sum} words; a WIDTH=4 instance is swept exhaustively.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic [4:0] exp4_q[$];

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .cin(cin4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation, scrambles the operands after the accepting edge and
  // watches the following cycles.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       output int lat, output int busy_cycles, output int n_done,
                       output logic [8:0] got, output bit moved);
    logic [7:0] prev;
    a = av; b = bv; cin = cv; start = 1'b1;
    exp_q.push_back(9'(av) + 9'(bv) + 9'(cv));
    tick();
    start = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    cin = 1'($urandom_range(0, 1));
    prev = sum;
    lat = -1; n_done = 0; got = '0; moved = 1'b0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        n_done++;
        if (lat < 0) begin
          lat = k;
          got = {cout, sum};
        end
      end else if (lat < 0 && sum !== prev) begin
        moved = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      tick();
      total++;
      if ({busy, done, cout, sum} !== 11'b0) begin
        bad++;
        $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all zero",
                 busy, done, cout, sum);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset: cycle %0d busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    int lat, bc, nd;
    logic [8:0] got, exp;
    bit moved;
    do_op(8'h25, 8'h1A, 1'b0, lat, bc, nd, got, moved);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL basic_sum: got %h, want %h", got, exp);
    end
    total++;
    if (lat !== 8) begin
      bad++; $display("FAIL basic_latency: got %0d, want 8", lat);
    end
    total++;
    if (bc !== 9) begin
      bad++; $display("FAIL basic_busy_cycles: got %0d, want 9", bc);
    end
    total++;
    if (nd !== 1 || moved) begin
      bad++; $display("FAIL basic_done_count_hold: dones=%0d partial=%0b, want 1 0", nd, moved);
    end
  endtask

  task automatic test_carry();
    int lat, bc, nd;
    logic [8:0] got, exp;
    bit moved;
    logic [7:0] av [2] = '{8'hFF, 8'hFF};
    logic [7:0] bv [2] = '{8'h01, 8'hFF};
    logic       cv [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      do_op(av[i], bv[i], cv[i], lat, bc, nd, got, moved);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp || nd !== 1) begin
        bad++;
        $display("FAIL carry_%0d: got %h dones=%0d, want %h dones=1", i, got, nd, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n_done;
    logic [8:0] got, exp;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h030);
    tick();
    start = 1'b0;
    n_done = 0; got = '0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        start = 1'b1; a = 8'h77; b = 8'h05;
      end else if (k == 4) begin
        start = 1'b0; a = 8'hC3; b = 8'h5A; cin = 1'b1;
      end
      tick();
      if (done === 1'b1) begin
        n_done++;
        got = {cout, sum};
      end
    end
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL busy_start_sum: got %h, want %h", got, exp);
    end
    total++;
    if (n_done !== 1) begin
      bad++; $display("FAIL busy_start_dones: got %0d, want 1", n_done);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, nd, spurious;
    logic [8:0] got, exp;
    bit moved;
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, cout, sum} !== 11'b0) begin
      bad++;
      $display("FAIL reset_mid_clear: busy=%b done=%b cout=%b sum=%h, want all zero",
               busy, done, cout, sum);
    end
    tick(); tick();
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) spurious++;
    end
    total++;
    if (spurious !== 0) begin
      bad++; $display("FAIL reset_mid_no_done: got %0d busy/done cycles, want 0", spurious);
    end
    do_op(8'h03, 8'h04, 1'b1, lat, bc, nd, got, moved);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp || lat !== 8) begin
      bad++; $display("FAIL reset_mid_after: got %h lat=%0d, want %h lat=8", got, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    int last_k, n_done, bad_gap, unstable;
    logic [7:0] last_sum;
    logic [8:0] exp;
    for (int i = 0; i < 3; i++) exp_q.push_back(9'h002);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    last_k = -2; n_done = 0; bad_gap = 0; unstable = 0;
    last_sum = sum;
    for (int k = 1; k <= 40; k++) begin
      if (k == 21) start = 1'b0;
      tick();
      if (done === 1'b1) begin
        n_done++;
        if ((last_k < 0 && k != 8) || (last_k >= 0 && k - last_k != 10)) bad_gap++;
        last_k = k;
        exp = exp_q.pop_front();
        total++;
        if ({cout, sum} !== exp) begin
          bad++; $display("FAIL b2b_sum: pulse %0d got %h, want %h", n_done, {cout, sum}, exp);
        end
        last_sum = sum;
      end else if (sum !== last_sum) begin
        unstable++;
      end
    end
    total++;
    if (n_done !== 3 || bad_gap !== 0) begin
      bad++; $display("FAIL b2b_timing: dones=%0d bad_gaps=%0d, want 3 0", n_done, bad_gap);
    end
    total++;
    if (unstable !== 0) begin
      bad++; $display("FAIL b2b_hold: sum changed %0d times between pulses, want 0", unstable);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL b2b_queue: %0d expected results left, want 0", exp_q.size());
    end
  endtask

  task automatic test_sweep4();
    int wait_k;
    logic [4:0] exp;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); start4 = 1'b1;
          exp4_q.push_back(5'(x) + 5'(y) + 5'(c));
          tick();
          start4 = 1'b0;
          a4 = ~a4; b4 = ~b4;
          wait_k = 0;
          while (done4 !== 1'b1 && wait_k < 10) begin
            tick();
            wait_k++;
          end
          exp = exp4_q.pop_front();
          total++;
          if (done4 !== 1'b1 || {cout4, sum4} !== exp) begin
            bad++;
            $display("FAIL sweep4: a=%h b=%h cin=%0d got done=%b %h, want done=1 %h",
                     x[3:0], y[3:0], c, done4, {cout4, sum4}, exp);
          end
          tick();
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0; cin = 1'b0; a = '0; b = '0;
    start4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    #2;
    test_reset();
    test_basic();
    test_carry();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_sweep4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
